// File: rtl/pipeline_flow_controller.sv
// rtl/pipeline_flow_controller.sv - branch redirect, load-use stall and drain control for a 5-stage pipeline
//
// Purpose: decides every cycle whether the PC and IF/ID registers load, whether
// IF/ID and ID/EX receive bubbles, and whether the PC is redirected to the
// EX-stage jump target. After a redirect the FSM drains FLUSH_DEPTH extra
// wrong-path fetches. Memory busywait freezes the whole pipeline.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   taken, target_addr   EX-stage redirect request and target
//   load_use_hazard      ID instruction needs the load currently in EX
//   imem_busywait,
//   dmem_busywait        memory stalls (freeze)
//   pc_sel, pc_target    next-PC select and redirect address
//   pc_write_en,
//   ifid_write_en        register load enables
//   ifid_flush,
//   idex_flush           bubble insertion on the next edge
//   draining             high while discarding wrong-path fetches
//   redirect_count,
//   stall_count          saturating statistics counters

module pipeline_flow_controller #(
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        taken,
  input  logic [31:0] target_addr,
  input  logic        load_use_hazard,
  input  logic        imem_busywait,
  input  logic        dmem_busywait,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        draining,
  output logic [15:0] redirect_count,
  output logic [15:0] stall_count
);

  localparam logic [2:0] DEPTH = FLUSH_DEPTH[2:0];

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [2:0] dcnt, dcnt_nxt;
  logic       redirect_inc;
  logic       stall_inc;
  logic       freeze;

  assign freeze = imem_busywait | dmem_busywait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      dcnt           <= 3'd0;
      redirect_count <= 16'd0;
      stall_count    <= 16'd0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      if (redirect_inc && redirect_count != 16'hFFFF)
        redirect_count <= redirect_count + 16'd1;
      if (stall_inc && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    dcnt_nxt      = dcnt;
    redirect_inc  = 1'b0;
    stall_inc     = 1'b0;
    pc_sel        = 1'b0;
    pc_target     = 32'd0;
    pc_write_en   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    draining      = 1'b0;

    if (!reset) begin
      // Both pipeline registers are held as bubbles while in reset.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (taken) begin
            // Redirect wins; a simultaneous hazard belongs to a squashed instruction.
            pc_sel        = 1'b1;
            pc_target     = target_addr;
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            redirect_inc  = 1'b1;
            if (DEPTH != 3'd0) begin
              state_nxt = DRAIN;
              dcnt_nxt  = DEPTH;
            end
          end else if (load_use_hazard) begin
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
          end
        end
        DRAIN: begin
          // taken/load_use_hazard come from wrong-path instructions here.
          draining      = 1'b1;
          pc_write_en   = 1'b1;
          ifid_write_en = 1'b1;
          ifid_flush    = 1'b1;
          if (dcnt <= 3'd1) begin
            state_nxt = IDLE;
            dcnt_nxt  = 3'd0;
          end else begin
            dcnt_nxt = dcnt - 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          dcnt_nxt  = 3'd0;
        end
      endcase

      // Freeze holds everything; pc_sel/pc_target/draining keep their values.
      if (freeze) begin
        state_nxt     = state;
        dcnt_nxt      = dcnt;
        redirect_inc  = 1'b0;
        stall_inc     = 1'b0;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// tb/tb_pipeline_flow_controller.sv - randomized and directed checks of pipeline_flow_controller
//
// Three instances (FLUSH_DEPTH 1, 3, 0) share one stimulus stream. A model that
// tracks remaining drain cycles and counter totals predicts all outputs and is
// compared on every falling edge; directed phases pin the model with literals.

module tb_pipeline_flow_controller;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        taken;
  logic [31:0] target_addr;
  logic        load_use_hazard;
  logic        imem_busywait;
  logic        dmem_busywait;

  logic        pc_sel_o        [N];
  logic [31:0] pc_target_o     [N];
  logic        pc_write_en_o   [N];
  logic        ifid_write_en_o [N];
  logic        ifid_flush_o    [N];
  logic        idex_flush_o    [N];
  logic        draining_o      [N];
  logic [15:0] redirect_cnt_o  [N];
  logic [15:0] stall_cnt_o     [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipeline_flow_controller #(
      .FLUSH_DEPTH((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .taken          (taken),
      .target_addr    (target_addr),
      .load_use_hazard(load_use_hazard),
      .imem_busywait  (imem_busywait),
      .dmem_busywait  (dmem_busywait),
      .pc_sel         (pc_sel_o[g]),
      .pc_target      (pc_target_o[g]),
      .pc_write_en    (pc_write_en_o[g]),
      .ifid_write_en  (ifid_write_en_o[g]),
      .ifid_flush     (ifid_flush_o[g]),
      .idex_flush     (idex_flush_o[g]),
      .draining       (draining_o[g]),
      .redirect_count (redirect_cnt_o[g]),
      .stall_count    (stall_cnt_o[g])
    );
  end

  function automatic int depth_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, k, got, exp, $time);
    end
  endtask

  // Model: cycles of wrong-path fetch still to discard, plus counter totals.
  int left [N];
  int rc   [N];
  int sc   [N];

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        left[k] = 0; rc[k] = 0; sc[k] = 0;
      end else if (!(imem_busywait || dmem_busywait)) begin
        if (left[k] > 0)
          left[k] = left[k] - 1;
        else if (taken) begin
          if (rc[k] < 65535) rc[k] = rc[k] + 1;
          left[k] = depth_of(k);
        end else if (load_use_hazard) begin
          if (sc[k] < 65535) sc[k] = sc[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic        f, e_sel, e_pcwe, e_ifwe, e_iff, e_idf, e_dr;
      logic [31:0] e_tgt;
      f = imem_busywait | dmem_busywait;
      e_sel = 0; e_tgt = 0; e_pcwe = 0; e_ifwe = 0; e_iff = 0; e_idf = 0; e_dr = 0;
      if (!reset) begin
        e_iff = 1; e_idf = 1;
      end else if (left[k] > 0) begin
        e_dr = 1; e_pcwe = !f; e_ifwe = !f; e_iff = !f;
      end else if (taken) begin
        e_sel = 1; e_tgt = target_addr;
        e_pcwe = !f; e_ifwe = !f; e_iff = !f; e_idf = !f;
      end else if (load_use_hazard) begin
        e_idf = !f;
      end else begin
        e_pcwe = !f; e_ifwe = !f;
      end
      chk("pc_sel", k, 32'(pc_sel_o[k]), 32'(e_sel));
      chk("pc_target", k, pc_target_o[k], e_tgt);
      chk("pc_write_en", k, 32'(pc_write_en_o[k]), 32'(e_pcwe));
      chk("ifid_write_en", k, 32'(ifid_write_en_o[k]), 32'(e_ifwe));
      chk("ifid_flush", k, 32'(ifid_flush_o[k]), 32'(e_iff));
      chk("idex_flush", k, 32'(idex_flush_o[k]), 32'(e_idf));
      chk("draining", k, 32'(draining_o[k]), 32'(e_dr));
      chk("redirect_count", k, 32'(redirect_cnt_o[k]), rc[k]);
      chk("stall_count", k, 32'(stall_cnt_o[k]), sc[k]);
    end
  end

  task automatic set_in(logic t, logic [31:0] a, logic h, logic im, logic dm);
    taken = t; target_addr = a; load_use_hazard = h; imem_busywait = im; dmem_busywait = dm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    set_in(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("rst_pc_write_en", 0, 32'(pc_write_en_o[0]), 32'd0);
    chk("rst_ifid_flush", 0, 32'(ifid_flush_o[0]), 32'd1);
    chk("rst_idex_flush", 0, 32'(idex_flush_o[0]), 32'd1);
    chk("rst_redirect_count", 0, 32'(redirect_cnt_o[0]), 32'd0);
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 32'd0, 0, 0, 0);
    do_reset();

    // One-cycle redirect with FLUSH_DEPTH=1.
    set_in(1, 32'h0000_0100, 0, 0, 0);
    @(negedge clk);
    chk("redir_pc_sel", 0, 32'(pc_sel_o[0]), 32'd1);
    chk("redir_pc_target", 0, pc_target_o[0], 32'h100);
    chk("redir_idex_flush", 0, 32'(idex_flush_o[0]), 32'd1);
    next_cycle();
    set_in(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("drain_draining", 0, 32'(draining_o[0]), 32'd1);
    chk("drain_ifid_flush", 0, 32'(ifid_flush_o[0]), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("post_draining", 0, 32'(draining_o[0]), 32'd0);
    chk("post_redirect_count", 0, 32'(redirect_cnt_o[0]), 32'd1);

    // Two-cycle load-use stall.
    next_cycle();
    set_in(0, 32'd0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_pc_write_en", 0, 32'(pc_write_en_o[0]), 32'd0);
      chk("stall_idex_flush", 0, 32'(idex_flush_o[0]), 32'd1);
      next_cycle();
    end
    set_in(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("stall_count_2", 0, 32'(stall_cnt_o[0]), 32'd2);
    chk("stall_release_we", 0, 32'(pc_write_en_o[0]), 32'd1);

    // Taken and hazard together: redirect only.
    next_cycle();
    set_in(1, 32'hABCD_0000, 1, 0, 0);
    @(negedge clk);
    chk("both_pc_sel", 0, 32'(pc_sel_o[0]), 32'd1);
    chk("both_pc_write_en", 0, 32'(pc_write_en_o[0]), 32'd1);
    next_cycle();
    set_in(0, 32'd0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("both_stall_count", 0, 32'(stall_cnt_o[0]), 32'd2);
    chk("both_redirect_count", 0, 32'(redirect_cnt_o[0]), 32'd2);

    // Redirect under instruction-memory freeze.
    next_cycle();
    set_in(1, 32'h200, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz_pc_write_en", 0, 32'(pc_write_en_o[0]), 32'd0);
      chk("frz_ifid_flush", 0, 32'(ifid_flush_o[0]), 32'd0);
      chk("frz_idex_flush", 0, 32'(idex_flush_o[0]), 32'd0);
      next_cycle();
    end
    chk("frz_redirect_count", 0, 32'(redirect_cnt_o[0]), 32'd2);
    imem_busywait = 1'b0;
    @(negedge clk);
    chk("unfrz_pc_write_en", 0, 32'(pc_write_en_o[0]), 32'd1);
    next_cycle();
    set_in(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("unfrz_redirect_count", 0, 32'(redirect_cnt_o[0]), 32'd3);
    chk("unfrz_draining", 0, 32'(draining_o[0]), 32'd1);

    // Reset during the 2nd drain cycle of the FLUSH_DEPTH=3 instance.
    do_reset();
    set_in(1, 32'h300, 0, 0, 0);
    next_cycle();
    set_in(0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("d3_drain1", 1, 32'(draining_o[1]), 32'd1);
    next_cycle();
    #1 reset = 1'b0;
    #1;
    chk("d3_abort_draining", 1, 32'(draining_o[1]), 32'd0);
    chk("d3_abort_redirect", 1, 32'(redirect_cnt_o[1]), 32'd0);
    chk("d3_abort_stall", 1, 32'(stall_cnt_o[1]), 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("d3_restart_idle", 1, 32'(draining_o[1]), 32'd0);
    chk("d3_restart_we", 1, 32'(pc_write_en_o[1]), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end
    next_cycle();
    reset = 1'b1;
    set_in(0, 32'd0, 0, 0, 0);

    // Saturation: continuous redirects on the FLUSH_DEPTH=0 instance.
    do_reset();
    set_in(1, 32'h400, 0, 0, 0);
    repeat (65540) next_cycle();
    @(negedge clk);
    chk("sat_redirect_count", 2, 32'(redirect_cnt_o[2]), 32'hFFFF);
    set_in(0, 32'd0, 0, 0, 0);
    next_cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_controller.md
PIPELINE_FLOW_CONTROLLER -- requirements
Module: pipeline_flow_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 FLUSH_DEPTH, default 1, SHALL set the number of extra IF/ID bubble cycles after a redirect, legal range 0..7.
REQ-003 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous active-low reset.
REQ-005 TAKEN  input  1  branch-taken or jump indication from the EX-stage jump logic.
REQ-006 TARGET_ADDR  input  32  branch or jump target from the EX-stage jump logic.
REQ-007 LOAD_USE_HAZARD  input  1  the ID-stage instruction depends on a load currently in EX.
REQ-008 IMEM_BUSYWAIT  input  1  instruction memory stall.
REQ-009 DMEM_BUSYWAIT  input  1  data memory stall.
REQ-010 PC_SEL  output  1  1 selects PC_TARGET as the next PC.
REQ-011 PC_TARGET  output  32  redirect address.
REQ-012 PC_WRITE_EN  output  1  PC register load enable.
REQ-013 IFID_WRITE_EN  output  1  IF/ID register load enable.
REQ-014 IFID_FLUSH  output  1  loads a NOP into IF/ID on the next edge.
REQ-015 IDEX_FLUSH  output  1  loads a bubble into ID/EX on the next edge.
REQ-016 DRAINING  output  1  high while the FSM is in DRAIN.
REQ-017 REDIRECT_COUNT  output  16  count of redirects taken.
REQ-018 STALL_COUNT  output  16  count of load-use stall cycles.

Function
REQ-019 FREEZE SHALL be defined as IMEM_BUSYWAIT | DMEM_BUSYWAIT.
REQ-020 While FREEZE=1, the block SHALL drive PC_WRITE_EN=0, IFID_WRITE_EN=0, IFID_FLUSH=0 and IDEX_FLUSH=0, and SHALL hold the FSM state, the drain counter and both statistics counters.
REQ-021 The FSM SHALL have two states, IDLE and DRAIN, plus a 3-bit drain counter DCNT.
REQ-022 In IDLE with TAKEN=1 (Mealy output, same cycle):
  - PC_SEL=1, PC_TARGET=TARGET_ADDR;
  - PC_WRITE_EN=1, IFID_WRITE_EN=1;
  - IFID_FLUSH=1, IDEX_FLUSH=1;
  - these values SHALL hold even under FREEZE, except for the REQ-020 overrides.
REQ-023 The TAKEN case in IDLE SHALL have priority over LOAD_USE_HAZARD; a simultaneous hazard SHALL be discarded and SHALL NOT increment STALL_COUNT.
REQ-024 On an IDLE edge with TAKEN=1 and FREEZE=0:
  - REDIRECT_COUNT SHALL increment, saturating at 0xFFFF;
  - if FLUSH_DEPTH=0, the FSM SHALL stay in IDLE;
  - otherwise it SHALL go to DRAIN with DCNT=FLUSH_DEPTH.
REQ-025 In IDLE with TAKEN=0 and LOAD_USE_HAZARD=1 and FREEZE=0:
  - PC_WRITE_EN=0, IFID_WRITE_EN=0, IDEX_FLUSH=1, IFID_FLUSH=0, PC_SEL=0;
  - STALL_COUNT SHALL increment, saturating at 0xFFFF;
  - the FSM SHALL remain in IDLE, so the stall lasts exactly as long as the hazard input is held.
REQ-026 In IDLE with no event, outputs SHALL be PC_SEL=0, PC_WRITE_EN=1, IFID_WRITE_EN=1, both flushes 0, with write enables still subject to REQ-020.
REQ-027 In DRAIN:
  - PC_SEL=0, PC_WRITE_EN=1, IFID_WRITE_EN=1, IFID_FLUSH=1, IDEX_FLUSH=0, DRAINING=1;
  - TAKEN and LOAD_USE_HAZARD SHALL be ignored, since they come from wrong-path instructions.
REQ-028 In DRAIN on each edge with FREEZE=0, DCNT SHALL decrement; when DCNT=1 at that edge, the next state SHALL be IDLE with DCNT=0.
REQ-029 PC_TARGET SHALL equal TARGET_ADDR whenever PC_SEL=1, and 0 otherwise.
REQ-030 The statistics counters SHALL NOT wrap; each SHALL hold at 0xFFFF.

Reset
REQ-031 While RESET=0, regardless of the clock:
  - the FSM SHALL be in IDLE and DCNT=0;
  - both counters SHALL be 0;
  - outputs SHALL be PC_SEL=0, PC_TARGET=0, PC_WRITE_EN=0, IFID_WRITE_EN=0, IFID_FLUSH=1, IDEX_FLUSH=1, DRAINING=0.
REQ-032 Reset asserted in DRAIN SHALL abort the drain immediately; after RESET rises, the first edge SHALL be evaluated from IDLE.

Verification
REQ-033 With FLUSH_DEPTH=1, a one-cycle pulse of TAKEN=1 and TARGET_ADDR=0x0000_0100 SHALL produce:
  - redirect cycle: PC_SEL=1, PC_TARGET=0x100, both flushes 1;
  - next cycle: DRAINING=1, IFID_FLUSH=1;
  - following cycle: back in IDLE, REDIRECT_COUNT=1.
REQ-034 LOAD_USE_HAZARD held for 2 cycles SHALL give 2 cycles of PC_WRITE_EN=0, IFID_WRITE_EN=0 and IDEX_FLUSH=1, then STALL_COUNT=2.
REQ-035 TAKEN=1 and LOAD_USE_HAZARD=1 in the same cycle SHALL produce redirect outputs only, with STALL_COUNT unchanged.
REQ-036 TAKEN=1 with IMEM_BUSYWAIT=1 for 3 cycles SHALL keep all enables and flushes at 0 and REDIRECT_COUNT unchanged; the redirect SHALL complete on the first edge after IMEM_BUSYWAIT falls.
REQ-037 With FLUSH_DEPTH=3, driving RESET=0 during the 2nd DRAIN cycle SHALL immediately give DRAINING=0 and both counters 0, and operation SHALL restart from IDLE after release.
REQ-038 After 0xFFFF redirects, a further redirect SHALL leave REDIRECT_COUNT at 0xFFFF.
